// File: rtl/pulse_spacer_pkg.sv
// rtl/pulse_spacer_pkg.sv - shared defaults and width helper for the pulse spacer
package pulse_spacer_pkg;

  localparam int PULSE_SPACER_GAP_DEF   = 9;
  localparam int PULSE_SPACER_CNT_W_DEF = 4;

  // Ceiling log2, never below 1 so a GAP of 1 still gets a legal timer vector.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pulse_spacer_1bit.sv
// rtl/pulse_spacer_1bit.sv - one channel: pending counter, gap timer, sticky overflow
// Optional flush input is built when PULSE_SPACER_FLUSH_EN is defined.
module pulse_spacer_1bit
  import pulse_spacer_pkg::*;
#(
  parameter int GAP     = PULSE_SPACER_GAP_DEF,
  parameter int CNT_W   = PULSE_SPACER_CNT_W_DEF,
  parameter int TIMER_W = clog2(GAP)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_i,
  input  logic ovf_clr_i,
`ifdef PULSE_SPACER_FLUSH_EN
  input  logic flush_i,
`endif
  output logic pulse_o,
  output logic busy_o,
  output logic overflow_o
);

  localparam logic [CNT_W-1:0]   PEND_MAX   = {CNT_W{1'b1}};
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(GAP - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  logic [CNT_W-1:0]   pend_q, pend_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pulse_q, pulse_d;
  logic               ovf_q, ovf_d;

  logic               flush;
  logic               emit;
  logic               drop;
  logic [CNT_W:0]     pend_sum;

`ifdef PULSE_SPACER_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    emit     = 1'b0;
    drop     = 1'b0;
    pend_sum = '0;
    pend_d   = pend_q;
    timer_d  = timer_q;
    pulse_d  = 1'b0;
    ovf_d    = ovf_q;

    // An arriving event emits straight through when the timer is idle.
    emit = (timer_q == '0) && ((pend_q != '0) || pulse_i) && !flush;

    // One extra bit lets a +1 at full be seen and clamped back to max.
    pend_sum = {1'b0, pend_q} + {{CNT_W{1'b0}}, pulse_i} - {{CNT_W{1'b0}}, emit};
    drop     = pulse_i && !emit && (pend_q == PEND_MAX) && !flush;

    if (flush) begin
      pend_d = '0;
    end else if (pend_sum[CNT_W]) begin
      pend_d = PEND_MAX;
    end else begin
      pend_d = pend_sum[CNT_W-1:0];
    end

    if (emit) begin
      timer_d = TIMER_LOAD;
    end else if (timer_q != '0) begin
      timer_d = timer_q - TIMER_ONE;
    end else begin
      timer_d = '0;
    end

    pulse_d = emit;

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      timer_q <= '0;
      pulse_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pulse_o    = pulse_q;
  assign busy_o     = (pend_q != '0) || (timer_q != '0);
  assign overflow_o = ovf_q;

endmodule

// File: rtl/pulse_spacer.sv
// rtl/pulse_spacer.sv - per-channel pacing of event pulses ahead of the CDC pulse stage
// Optional flush port is built when PULSE_SPACER_FLUSH_EN is defined.
module pulse_spacer
  import pulse_spacer_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int GAP   = PULSE_SPACER_GAP_DEF,
  parameter int CNT_W = PULSE_SPACER_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pulse_in,
  input  logic [WIDTH-1:0] ovf_clr,
`ifdef PULSE_SPACER_FLUSH_EN
  input  logic [WIDTH-1:0] flush,
`endif
  output logic [WIDTH-1:0] pulse_out,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] overflow
);

  localparam int TIMER_W = clog2(GAP);

  // Channels never interact; each one paces its own stream.
  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    pulse_spacer_1bit #(
      .GAP     (GAP),
      .CNT_W   (CNT_W),
      .TIMER_W (TIMER_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .pulse_i    (pulse_in[g]),
      .ovf_clr_i  (ovf_clr[g]),
`ifdef PULSE_SPACER_FLUSH_EN
      .flush_i    (flush[g]),
`endif
      .pulse_o    (pulse_out[g]),
      .busy_o     (busy[g]),
      .overflow_o (overflow[g])
    );
  end

endmodule
